stream_feeder: RTL

STREAM_FEEDER -- requirements
Module: stream_feeder

---
 rtl/stream_feeder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stream_feeder.sv
// Read-only streamer: fetches data_length words from a BRAM starting at base_addr
// and presents them as an AXI-Stream through a 2-entry skid buffer.
module stream_feeder #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  input  logic [pADDR_WIDTH-1:0] base_addr,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   buf_EN,
  output logic [3:0]             buf_WE,
  output logic [pADDR_WIDTH-1:0] buf_A,
  output logic [pDATA_WIDTH-1:0] buf_Di,
  input  logic [pDATA_WIDTH-1:0] buf_Do
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   done_q, done_d;
  logic [31:0]            len_q, len_d;
  logic [pADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]            idx_q, idx_d;
  logic                   infl_q, infl_d;
  logic                   infl_last_q, infl_last_d;
  logic [1:0]             occ_q, occ_d;
  logic [pDATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                   last0_q, last0_d, last1_q, last1_d;

  logic       pop;
  logic       rd_en;
  logic       rd_last;
  logic [2:0] occ_eff;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    len_d       = len_q;
    base_d      = base_q;
    idx_d       = idx_q;
    occ_d       = occ_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;

    pop     = (occ_q != 2'd0) && sm_tready;
    // Occupancy net of this cycle's handshake, so a read can be issued into the
    // slot being freed; without it the 1-cycle read latency caps throughput at 1/2.
    occ_eff = {1'b0, occ_q} - {2'b00, pop};
    rd_en   = (state_q == S_RUN) && ((occ_eff + {2'b00, infl_q}) < 3'd2);
    rd_last = (idx_q == len_q - 32'd1);

    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (infl_q) begin
      if (occ_eff[1:0] == 2'd0) begin
        data0_d = buf_Do;
        last0_d = infl_last_q;
      end else begin
        data1_d = buf_Do;
        last1_d = infl_last_q;
      end
    end
    occ_d       = occ_eff[1:0] + {1'b0, infl_q};
    infl_d      = rd_en;
    infl_last_d = rd_en && rd_last;

    if (rd_en) begin
      idx_d = idx_q + 32'd1;
      if (rd_last) state_d = S_DRAIN;
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          if (data_length == 32'd0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            len_d   = data_length;
            base_d  = base_addr;
            idx_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && last0_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      len_q       <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      len_q       <= len_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
    end
  end

  assign ap_idle   = (state_q == S_IDLE);
  assign ap_done   = done_q;
  assign sm_tvalid = (occ_q != 2'd0);
  assign sm_tdata  = data0_q;
  assign sm_tlast  = sm_tvalid && last0_q;
  assign buf_EN    = rd_en;
  assign buf_WE    = '0;
  assign buf_Di    = '0;
  assign buf_A     = base_q + {idx_q[pADDR_WIDTH-3:0], 2'b00};

endmodule
